// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared state encoding, default block size and stage-select encoding
package dct_pkg;

  localparam int DCT_DIM_DEFAULT = 8;

  localparam logic STAGE_SEL_ROW = 1'b1;
  localparam logic STAGE_SEL_COL = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_COL  = 2'd2,
    ST_DONE = 2'd3
  } dct_state_e;

endpackage

// File: rtl/dct_stage_ctrl_if.sv
// rtl/dct_stage_ctrl_if.sv - control, handshake and transpose-buffer signals of the DCT stage controller
interface dct_stage_ctrl_if import dct_pkg::*; #(
  parameter int DIM   = DCT_DIM_DEFAULT,
  parameter int CNT_W = 16
);
  localparam int AW = $clog2(DIM);

  logic            start;
  logic            abort;
  logic            in_valid;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic            stage_sel;
  logic            tbuf_wr_en;
  logic [AW-1:0]   tbuf_wr_addr;
  logic            tbuf_rd_en;
  logic [AW-1:0]   tbuf_rd_addr;
  logic            busy;
  logic            done;
  logic [CNT_W-1:0] blk_cnt;

  modport master (
    output start, abort, in_valid, out_ready,
    input  in_ready, out_valid, stage_sel, tbuf_wr_en, tbuf_wr_addr,
           tbuf_rd_en, tbuf_rd_addr, busy, done, blk_cnt
  );

  modport slave (
    input  start, abort, in_valid, out_ready,
    output in_ready, out_valid, stage_sel, tbuf_wr_en, tbuf_wr_addr,
           tbuf_rd_en, tbuf_rd_addr, busy, done, blk_cnt
  );

endinterface

// File: rtl/dct_beat_counter.sv
// rtl/dct_beat_counter.sv - modulo-DIM beat counter with terminal flag and sticky wrap flag
module dct_beat_counter import dct_pkg::*; #(
  parameter  int DIM = DCT_DIM_DEFAULT,
  localparam int AW  = $clog2(DIM)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [AW-1:0] cnt_o,
  output logic          last_o,
  output logic          full_o
);

  logic [AW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;

  assign last_o = (cnt_q == AW'(DIM - 1));
  assign cnt_o  = cnt_q;
  assign full_o = full_q;

  // full_o records that all DIM beats were counted, since cnt_q itself wraps back to 0
  always_comb begin
    cnt_d  = cnt_q;
    full_d = full_q;
    if (clr_i) begin
      cnt_d  = '0;
      full_d = 1'b0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
      if (last_o) full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/dct_stage_ctrl.sv
// rtl/dct_stage_ctrl.sv - row/column sequencing of one DIMxDIM 2-D DCT block through a transpose buffer
// DCT_CTRL_BLK_CNT_EN enables the completed-block counter on blk_cnt.
module dct_stage_ctrl import dct_pkg::*; #(
  parameter int DIM   = DCT_DIM_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  dct_stage_ctrl_if.slave    bus
);

  localparam int AW = $clog2(DIM);

  dct_state_e    state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] row_cnt, iss_cnt, out_cnt_unused;
  logic          row_last, iss_full, out_last;
  logic          row_full_unused, iss_last_unused, out_full_unused;
  logic          row_inc, row_clr, col_clr, rd_en, out_fire;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    row_inc     = (state_q == ST_ROW) && bus.in_valid;
    out_fire    = out_valid_q && bus.out_ready;
    rd_en       = (state_q == ST_COL) && !iss_full && (!out_valid_q || bus.out_ready);
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_ROW;
      ST_ROW:  if (row_inc && row_last) state_d = ST_COL;
      ST_COL: begin
        // the read issued this cycle refills the output slot one cycle later
        if (rd_en)         out_valid_d = 1'b1;
        else if (out_fire) out_valid_d = 1'b0;
        if (out_fire && out_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.abort) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign row_clr = bus.abort || (state_q == ST_IDLE);
  assign col_clr = bus.abort || (state_q != ST_COL);

  dct_beat_counter #(.DIM(DIM)) u_row_cnt (
    .clk_i(HCLK), .rst_n_i(HRESETn), .clr_i(row_clr), .inc_i(row_inc),
    .cnt_o(row_cnt), .last_o(row_last), .full_o(row_full_unused)
  );

  dct_beat_counter #(.DIM(DIM)) u_iss_cnt (
    .clk_i(HCLK), .rst_n_i(HRESETn), .clr_i(col_clr), .inc_i(rd_en),
    .cnt_o(iss_cnt), .last_o(iss_last_unused), .full_o(iss_full)
  );

  dct_beat_counter #(.DIM(DIM)) u_out_cnt (
    .clk_i(HCLK), .rst_n_i(HRESETn), .clr_i(col_clr), .inc_i(out_fire),
    .cnt_o(out_cnt_unused), .last_o(out_last), .full_o(out_full_unused)
  );

  assign bus.in_ready     = (state_q == ST_ROW);
  assign bus.out_valid    = out_valid_q;
  assign bus.stage_sel    = (state_q == ST_COL) ? STAGE_SEL_COL : STAGE_SEL_ROW;
  assign bus.tbuf_wr_en   = row_inc;
  assign bus.tbuf_wr_addr = row_cnt;
  assign bus.tbuf_rd_en   = rd_en;
  assign bus.tbuf_rd_addr = iss_cnt;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.done         = (state_q == ST_DONE);

`ifdef DCT_CTRL_BLK_CNT_EN
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

  assign blk_cnt_d = (state_q == ST_DONE) ? blk_cnt_q + 1'b1 : blk_cnt_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) blk_cnt_q <= '0;
    else          blk_cnt_q <= blk_cnt_d;
  end

  assign bus.blk_cnt = blk_cnt_q;
`else
  assign bus.blk_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_dct_stage_ctrl.sv
// tb/tb_dct_stage_ctrl.sv - self-checking bench for dct_stage_ctrl: vector table, directed corners, random vs model
module tb_dct_stage_ctrl;

  localparam int DIM   = 8;
  localparam int CNT_W = 2;
`ifdef DCT_CTRL_BLK_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  dct_stage_ctrl_if #(.DIM(DIM), .CNT_W(CNT_W)) bus ();
  dct_stage_ctrl #(.DIM(DIM), .CNT_W(CNT_W)) dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));

  typedef struct {
    bit s, a, iv, ordy;
    bit busy, inr, sel, wr;
    int wra;
    bit rd;
    int rda;
    bit ov, done;
  } vec_t;

  vec_t vecs[20];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model: block phase 0 idle, 1 rows, 2 columns, 3 done
  int m_ph, m_rows, m_iss, m_acc, m_blocks;
  bit m_ov;

  bit obs_inr, obs_busy, obs_rd, obs_ov, obs_sel, obs_done;
  int fires_seen, dones_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit s, bit a, bit iv, bit ordy, bit busy, bit inr, bit sel,
                              bit wr, int wra, bit rd, int rda, bit ov, bit done);
    vec_t v;
    v.s = s; v.a = a; v.iv = iv; v.ordy = ordy;
    v.busy = busy; v.inr = inr; v.sel = sel; v.wr = wr; v.wra = wra;
    v.rd = rd; v.rda = rda; v.ov = ov; v.done = done;
    return v;
  endfunction

  function automatic int exp_blk();
    return CNT_EN ? (m_blocks % (1 << CNT_W)) : 0;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_rows = 0; m_iss = 0; m_acc = 0; m_blocks = 0; m_ov = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  bus.in_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_wr_en"},     bus.tbuf_wr_en, 0);
    chk({tag, "_rd_en"},     bus.tbuf_rd_en, 0);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_done"},      bus.done, 0);
    chk({tag, "_blk_cnt"},   bus.blk_cnt, 0);
    chk({tag, "_stage_sel"}, bus.stage_sel, 1);
  endtask

  // one clock: drive after the rising edge, compare at the falling edge, advance the model
  task automatic step_v(input vec_t v, input bit use_v);
    bit e_rd, fire;
    bus.start = v.s; bus.abort = v.a; bus.in_valid = v.iv; bus.out_ready = v.ordy;
    @(negedge HCLK);
    e_rd = (m_ph == 2) && (m_iss < DIM) && (!m_ov || v.ordy);
    chk("m_busy",     bus.busy,       m_ph != 0);
    chk("m_in_ready", bus.in_ready,   m_ph == 1);
    chk("m_stage",    bus.stage_sel,  m_ph != 2);
    chk("m_wr_en",    bus.tbuf_wr_en, (m_ph == 1) && v.iv);
    if (m_ph == 1 && v.iv) chk("m_wr_addr", bus.tbuf_wr_addr, m_rows % DIM);
    chk("m_rd_en",    bus.tbuf_rd_en, e_rd);
    if (e_rd) chk("m_rd_addr", bus.tbuf_rd_addr, m_iss % DIM);
    chk("m_out_valid", bus.out_valid, m_ov);
    chk("m_done",     bus.done,       m_ph == 3);
    chk("m_blk_cnt",  bus.blk_cnt,    exp_blk());
    if (use_v) begin
      chk("v_busy",      bus.busy,       v.busy);
      chk("v_in_ready",  bus.in_ready,   v.inr);
      chk("v_stage",     bus.stage_sel,  v.sel);
      chk("v_wr_en",     bus.tbuf_wr_en, v.wr);
      if (v.wr) chk("v_wr_addr", bus.tbuf_wr_addr, v.wra);
      chk("v_rd_en",     bus.tbuf_rd_en, v.rd);
      if (v.rd) chk("v_rd_addr", bus.tbuf_rd_addr, v.rda);
      chk("v_out_valid", bus.out_valid,  v.ov);
      chk("v_done",      bus.done,       v.done);
    end
    obs_inr = bus.in_ready; obs_busy = bus.busy; obs_rd = bus.tbuf_rd_en;
    obs_ov = bus.out_valid; obs_sel = bus.stage_sel; obs_done = bus.done;
    if (bus.out_valid && v.ordy) fires_seen++;
    if (bus.done) dones_seen++;
    if (m_ph == 3) m_blocks++;
    if (v.a) begin
      m_ph = 0; m_rows = 0; m_iss = 0; m_acc = 0; m_ov = 1'b0;
    end else begin
      case (m_ph)
        0: if (v.s) begin m_ph = 1; m_rows = 0; end
        1: if (v.iv) begin
             m_rows++;
             if (m_rows == DIM) begin m_ph = 2; m_rows = 0; m_iss = 0; m_acc = 0; end
           end
        2: begin
             fire = m_ov && v.ordy;
             if (fire) m_acc++;
             if (e_rd) begin m_iss++; m_ov = 1'b1; end
             else if (fire) m_ov = 1'b0;
             if (m_acc == DIM) m_ph = 3;
           end
        default: m_ph = 0;
      endcase
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic step(input bit s, input bit a, input bit iv, input bit ordy);
    step_v(mk(s, a, iv, ordy, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
  endtask

  task automatic run_block(input string tag);
    bit got;
    got = 1'b0;
    step(1, 0, 0, 1);
    for (int i = 0; i < DIM; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 4 * DIM && !got; i++) begin
      step(0, 0, 0, 1);
      got = obs_done;
    end
    chk({tag, "_done_seen"}, got, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got;
    vecs[0] = mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) vecs[k] = mk(0, 0, 1, 1, 1, 1, 1, 1, k - 1, 0, 0, 0, 0);
    vecs[9] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 10; k <= 16; k++) vecs[k] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, k - 9, 1, 0);
    vecs[17] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[18] = mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    vecs[19] = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.out_ready = 0;
    model_reset();
    fires_seen = 0; dones_seen = 0;
    #12;
    chk_reset_outputs("por");
    @(posedge HCLK); #2;
    HRESETn = 1'b1;

    // basic block from the vector table
    for (int i = 0; i < 20; i++) step_v(vecs[i], 1'b1);
    chk("basic_blk_cnt", bus.blk_cnt, CNT_EN ? 1 : 0);

    // back-pressure after the second accepted beat
    fires_seen = 0; dones_seen = 0;
    step(1, 0, 0, 1);
    for (int i = 0; i < DIM; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 10 && fires_seen < 2; i++) step(0, 0, 0, 1);
    chk("bp_two_beats", fires_seen, 2);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("bp_stall_rd", obs_rd, 0);
      chk("bp_stall_ov", obs_ov, 1);
      chk("bp_stall_sel", obs_sel, 0);
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(0, 0, 0, 1);
      got = obs_done;
    end
    chk("bp_beats", fires_seen, DIM);
    chk("bp_done", dones_seen, 1);

    // abort on the fifth row beat
    dones_seen = 0;
    step(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    step(0, 0, 0, 1);
    chk("abort_in_ready", obs_inr, 0);
    chk("abort_busy", obs_busy, 0);
    chk("abort_no_done", dones_seen, 0);
    chk("abort_blk_cnt", bus.blk_cnt, CNT_EN ? 2 : 0);
    run_block("after_abort");
    chk("after_abort_dones", dones_seen, 1);

    // start pulses in ROW and in DONE are ignored
    dones_seen = 0;
    step(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
    step(1, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 16; i++) step(m_ph == 3, 0, 0, 1);
    chk("start_busy_idle", obs_busy, 0);
    chk("start_busy_dones", dones_seen, 1);

    // asynchronous reset while in the column phase
    dones_seen = 0;
    step(1, 0, 0, 1);
    for (int i = 0; i < DIM; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    bus.start = 0; bus.in_valid = 0;
    model_reset();
    @(posedge HCLK); #2;
    HRESETn = 1'b1;
    step(0, 0, 0, 1);
    chk("rst_no_done", dones_seen, 0);

    // block counter wraps at 2^CNT_W
    for (int k = 1; k <= 5; k++) begin
      run_block("wrap");
      chk("wrap_blk_cnt", bus.blk_cnt, CNT_EN ? (k % 4) : 0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dct_stage_ctrl.md
DCT_STAGE_CTRL -- requirements
Module: dct_stage_ctrl

Interface
REQ-001 SHALL have parameter DIM, default 8: rows/columns per block, power of two, at least 2.
REQ-002 SHALL have parameter CNT_W, default 16: width of the block-count output.
REQ-003 SHALL have port HCLK, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port HRESETn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: one-cycle request to process one DIMxDIM block.
REQ-006 SHALL have port abort, input, 1: synchronous cancel of the current block.
REQ-007 SHALL have port in_valid / in_ready, input / output, 1 each: row-input handshake.
REQ-008 SHALL have port out_valid / out_ready, output / input, 1 each: column-result handshake.
REQ-009 SHALL have port stage_sel, output, 1: datapath clipping select; 1 = first (row) stage, 0 = second (column) stage.
REQ-010 SHALL have ports tbuf_wr_en (output, 1) and tbuf_wr_addr (output, $clog2(DIM)): transpose-buffer row write.
REQ-011 SHALL have ports tbuf_rd_en (output, 1) and tbuf_rd_addr (output, $clog2(DIM)): transpose-buffer column read; the buffer has fixed 1-cycle read latency.
REQ-012 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and blk_cnt (output, CNT_W).

Function
REQ-013 SHALL implement states IDLE, ROW, COL and DONE.
REQ-014 IDLE: busy=0, in_ready=0; start=1 -> ROW next cycle; row counter cleared to 0.
REQ-015 ROW: stage_sel=1, in_ready=1; each in_valid&&in_ready beat SHALL assert tbuf_wr_en combinationally, with tbuf_wr_addr = row counter, then increment the counter.
REQ-016 The DIM-th ROW beat SHALL move to COL next cycle, with read and output counters cleared.
REQ-017 COL: stage_sel=0, in_ready=0; tbuf_rd_en SHALL assert when issued<DIM and (!out_valid || out_ready); tbuf_rd_addr = issue counter.
REQ-018 out_valid SHALL rise exactly 1 cycle after a tbuf_rd_en; it SHALL hold stable while out_ready=0; back-to-back reads SHALL sustain 1 beat/cycle.
REQ-019 The DIM-th accepted out beat SHALL move to DONE; DONE asserts done for exactly 1 cycle, then returns to IDLE.
REQ-020 start SHALL be ignored unless the state is IDLE, including during DONE.
REQ-021 abort SHALL force IDLE on the next cycle from any state, clear all counters and deassert out_valid; it SHALL NOT pulse done or increment blk_cnt.
REQ-022 If abort and start are asserted together, abort SHALL win and the block SHALL stay IDLE.
REQ-023 busy SHALL be 1 in ROW, COL and DONE.
REQ-024 Counters SHALL wrap at DIM without reaching an out-of-range address.

Reset
REQ-025 HRESETn low SHALL put the block in IDLE with all counters 0 and outputs in_ready, out_valid, tbuf_wr_en, tbuf_rd_en, busy, done and blk_cnt at 0; stage_sel SHALL reset to 1.
REQ-026 Reset mid-block SHALL discard the block, with no done pulse.

Configuration
REQ-027 With DCT_CTRL_BLK_CNT_EN defined, blk_cnt SHALL increment by 1 in the DONE cycle, wrapping at 2^CNT_W.
REQ-028 Without DCT_CTRL_BLK_CNT_EN, blk_cnt SHALL be constant 0 and no counter flops SHALL be inferred.

Structure
REQ-029 The state enum, default DIM and clipping-stage select encoding SHALL live in shared package dct_pkg.
REQ-030 The row/issue/output counters SHALL be instances of one sub-module, dct_beat_counter (clear, increment, terminal-count flag).

Verification
REQ-031 Basic block: start, then 8 in beats on 8 consecutive cycles -> tbuf_wr_addr 0..7, stage_sel=1; then 8 reads with addr 0..7; out_valid for 8 cycles; done 1 cycle; blk_cnt=1 with the macro defined.
REQ-032 Back-pressure: out_ready low for 3 cycles after the 2nd out beat -> tbuf_rd_en held low, out_valid and stage_sel=0 held; exactly 8 accepted beats; done after the last beat.
REQ-033 Abort: abort at in beat 5 -> IDLE next cycle, in_ready=0, no done, blk_cnt unchanged; a new start then completes normally.
REQ-034 Start while busy: start pulses in ROW and DONE -> ignored; exactly one done per accepted start.
REQ-035 Reset: HRESETn low during COL -> all outputs 0 and stage_sel=1 asynchronously; after release, IDLE and start works.
REQ-036 Counter wrap: CNT_W=2, 5 blocks -> blk_cnt reads 1,2,3,0,1; without the macro it reads 0 throughout.
